// File: rtl/sc_axi_slave_bridge.sv
// sc_axi_slave_bridge: AXI4 responder that replays every burst beat as a
// single-beat request on the sc_* backend channel. One AXI transaction is in
// flight at a time.
// Optional build macro: SC_AXI_BRIDGE_WLAST_CHK_EN (wlast consistency check).
module sc_axi_slave_bridge #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 40,
  parameter int ID_WIDTH   = 12
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [ID_WIDTH-1:0]     axi_awid,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic [2:0]              axi_awsize,
  input  logic [1:0]              axi_awburst,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wlast,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ID_WIDTH-1:0]     axi_arid,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic [2:0]              axi_arsize,
  input  logic [1:0]              axi_arburst,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [ID_WIDTH-1:0]     axi_rid,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic                    sc_req_valid,
  input  logic                    sc_req_ready,
  output logic                    sc_req_we,
  output logic [ADDR_WIDTH-1:0]   sc_req_addr,
  output logic [DATA_WIDTH-1:0]   sc_req_wdata,
  output logic [DATA_WIDTH/8-1:0] sc_req_wstrb,
  output logic [ID_WIDTH-1:0]     sc_req_id,
  input  logic                    sc_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   sc_rsp_rdata,
  input  logic                    sc_rsp_err
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int MAX_SIZE = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DATA, S_WR_REQ, S_WR_WAIT, S_WR_RESP, S_RD_REQ, S_RD_WAIT, S_RD_DATA
  } state_t;

  state_t                  r_state, w_next;
  logic [ID_WIDTH-1:0]     r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len, r_cnt;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic                    r_err;      // sticky write error -> bresp SLVERR
  logic                    r_bad;      // burst never reaches the backend
  logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
  logic [STRB_W-1:0]       r_wstrb;
  logic                    r_rerr;     // per-beat read error
  logic                    r_last_rd;  // 1: read wins the next contested grant

  logic                    w_gnt_wr, w_gnt_rd, w_both;
  logic                    w_aw_hs, w_ar_hs, w_w_hs, w_req_hs, w_last_beat;
  logic [ADDR_WIDTH-1:0]   w_n, w_b, w_next_addr;

  // Unsupported burst type, oversize beat or illegal wrap length.
  function automatic logic f_bad(input logic [1:0] burst, input logic [2:0] size,
                                 input logic [7:0] len);
    return (burst == 2'b11) || (size > 3'(MAX_SIZE)) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // Round robin only advances on contested grants, so an uncontested grant
  // does not steal the other side's turn.
  assign w_both      = axi_awvalid & axi_arvalid;
  assign w_gnt_wr    = axi_awvalid & (~axi_arvalid | ~r_last_rd);
  assign w_gnt_rd    = axi_arvalid & ~w_gnt_wr;
  assign w_aw_hs     = axi_awvalid & axi_awready;
  assign w_ar_hs     = axi_arvalid & axi_arready;
  assign w_w_hs      = axi_wvalid & axi_wready;
  assign w_req_hs    = sc_req_valid & sc_req_ready;
  assign w_last_beat = (r_cnt == r_len);

  // Beat address stepping for FIXED / INCR / WRAP.
  always_comb begin
    w_n = ADDR_WIDTH'(1) << r_size;
    w_b = (w_n * ADDR_WIDTH'(r_len)) + w_n;
    case (r_burst)
      2'b01:   w_next_addr = (r_addr & ~(w_n - ADDR_WIDTH'(1))) + w_n;
      2'b10:   w_next_addr = (r_addr & ~(w_b - ADDR_WIDTH'(1))) |
                             ((r_addr + w_n) & (w_b - ADDR_WIDTH'(1)));
      default: w_next_addr = r_addr;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_aw_hs) w_next = S_WR_DATA;
                 else if (w_ar_hs) w_next = S_RD_REQ;
      S_WR_DATA: if (w_w_hs) begin
                   if (!r_bad)           w_next = S_WR_REQ;
                   else if (w_last_beat) w_next = S_WR_RESP;
                 end
      S_WR_REQ:  if (w_req_hs) w_next = S_WR_WAIT;
      S_WR_WAIT: if (sc_rsp_valid) w_next = w_last_beat ? S_WR_RESP : S_WR_DATA;
      S_WR_RESP: if (axi_bready) w_next = S_IDLE;
      S_RD_REQ:  if (r_bad) w_next = S_RD_DATA;
                 else if (w_req_hs) w_next = S_RD_WAIT;
      S_RD_WAIT: if (sc_rsp_valid) w_next = S_RD_DATA;
      S_RD_DATA: if (axi_rready) w_next = w_last_beat ? S_IDLE : S_RD_REQ;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched burst context.
  always_comb begin
    axi_awready  = 1'b0;
    axi_arready  = 1'b0;
    axi_wready   = 1'b0;
    axi_bvalid   = 1'b0;
    axi_bid      = '0;
    axi_bresp    = 2'b00;
    axi_rvalid   = 1'b0;
    axi_rid      = '0;
    axi_rdata    = '0;
    axi_rresp    = 2'b00;
    axi_rlast    = 1'b0;
    sc_req_valid = 1'b0;
    sc_req_we    = 1'b0;
    sc_req_addr  = '0;
    sc_req_wdata = '0;
    sc_req_wstrb = '0;
    sc_req_id    = '0;
    case (r_state)
      S_IDLE: begin
        axi_awready = w_gnt_wr;
        axi_arready = w_gnt_rd;
      end
      S_WR_DATA: axi_wready = 1'b1;
      S_WR_REQ: begin
        sc_req_valid = 1'b1;
        sc_req_we    = 1'b1;
        sc_req_addr  = r_addr;
        sc_req_wdata = r_wdata;
        sc_req_wstrb = r_wstrb;
        sc_req_id    = r_id;
      end
      S_WR_RESP: begin
        axi_bvalid = 1'b1;
        axi_bid    = r_id;
        axi_bresp  = r_err ? 2'b10 : 2'b00;
      end
      S_RD_REQ: if (!r_bad) begin
        sc_req_valid = 1'b1;
        sc_req_addr  = r_addr;
        sc_req_id    = r_id;
      end
      S_RD_DATA: begin
        axi_rvalid = 1'b1;
        axi_rid    = r_id;
        axi_rdata  = r_rdata;
        axi_rresp  = r_rerr ? 2'b10 : 2'b00;
        axi_rlast  = w_last_beat;
      end
      default: ;
    endcase
  end

`ifndef SC_AXI_BRIDGE_WLAST_CHK_EN
  logic w_unused_wlast;
  assign w_unused_wlast = axi_wlast;
`endif

  // Burst context, beat data and error tracking.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0;
      r_burst <= '0; r_err <= 1'b0; r_bad <= 1'b0; r_wdata <= '0;
      r_wstrb <= '0; r_rdata <= '0; r_rerr <= 1'b0; r_last_rd <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_id <= axi_awid; r_addr <= axi_awaddr; r_len <= axi_awlen;
            r_size <= axi_awsize; r_burst <= axi_awburst; r_cnt <= '0;
            r_bad <= f_bad(axi_awburst, axi_awsize, axi_awlen);
            r_err <= f_bad(axi_awburst, axi_awsize, axi_awlen);
            if (w_both) r_last_rd <= 1'b1;
          end else if (w_ar_hs) begin
            r_id <= axi_arid; r_addr <= axi_araddr; r_len <= axi_arlen;
            r_size <= axi_arsize; r_burst <= axi_arburst; r_cnt <= '0;
            r_bad <= f_bad(axi_arburst, axi_arsize, axi_arlen);
            r_err <= 1'b0;
            if (w_both) r_last_rd <= 1'b0;
          end
        end
        S_WR_DATA: if (w_w_hs) begin
          r_wdata <= axi_wdata;
          r_wstrb <= axi_wstrb;
`ifdef SC_AXI_BRIDGE_WLAST_CHK_EN
          if (axi_wlast != w_last_beat) r_err <= 1'b1;
`endif
          // Error bursts never visit WR_WAIT, so step the beat here.
          if (r_bad && !w_last_beat) begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= w_next_addr;
          end
        end
        S_WR_WAIT: if (sc_rsp_valid) begin
          r_err <= r_err | sc_rsp_err;
          if (!w_last_beat) begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= w_next_addr;
          end
        end
        S_RD_REQ: if (r_bad) begin
          r_rdata <= '0;
          r_rerr  <= 1'b1;
        end
        S_RD_WAIT: if (sc_rsp_valid) begin
          r_rdata <= sc_rsp_rdata;
          r_rerr  <= sc_rsp_err;
        end
        S_RD_DATA: if (axi_rready && !w_last_beat) begin
          r_cnt  <= r_cnt + 8'd1;
          r_addr <= w_next_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sc_axi_slave_bridge.md
# sc_axi_slave_bridge

AXI4 responder that terminates a memory-mapped AXI burst interface and replays each beat as a single-beat request on the simple `sc_*`-style request/response channel used by the SystemC memory backend (DPI-C side). It is the target-side counterpart of the SystemC-mode path into the OpenDDR controller. It lets the controller's AXI traffic, or testbench traffic, be serviced by a SystemC memory model. One AXI transaction is in flight at a time; bursts are serialised beat-by-beat.

## Interface
- `DATA_WIDTH`, 64, AXI and backend data width; must be a power of two, at least 8.
- `ADDR_WIDTH`, 40, AXI and backend address width.
- `ID_WIDTH`, 12, AXI ID width.
- `sys_clk` in 1: single clock, rising edge.
- `sys_rst` in 1: reset, synchronous, active-high.
- `axi_aw{id,addr,len,size,burst}` in: write address channel; widths ID_WIDTH/ADDR_WIDTH/8/3/2.
- `axi_awvalid` in 1; `axi_awready` out 1.
- `axi_w{data,strb,last,valid}` in: DATA_WIDTH / DATA_WIDTH/8 / 1 / 1.
- `axi_wready` out 1.
- `axi_b{id,resp,valid}` out: ID_WIDTH / 2 / 1.
- `axi_bready` in 1.
- `axi_ar{id,addr,len,size,burst,valid}` in: same widths as AW; `axi_arready` out 1.
- `axi_r{id,data,resp,last,valid}` out: ID_WIDTH / DATA_WIDTH / 2 / 1 / 1.
- `axi_rready` in 1.
- `sc_req_valid` out 1; `sc_req_ready` in 1: backend request handshake.
- `sc_req_we` out 1: 1 = write beat.
- `sc_req_addr` out ADDR_WIDTH; `sc_req_wdata` out DATA_WIDTH; `sc_req_wstrb` out DATA_WIDTH/8; `sc_req_id` out ID_WIDTH.
- `sc_rsp_valid` in 1: one response per accepted request (reads and writes).
- `sc_rsp_rdata` in DATA_WIDTH; `sc_rsp_err` in 1.

## Operation
- States: IDLE, WR_DATA, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_DATA.
- IDLE arbitration:
  - Only AW valid: write granted. Only AR valid: read granted.
  - Both valid: round-robin. A `last_rd` flag (reset 0) gives priority to write after reset and to the opposite type of the last grant.
  - The granted channel's ready is high in IDLE combinationally on its valid. The other ready is 0.
- Handshake latches id, addr, len, size, burst; beat counter = 0; error flag = 0.
  - Write → WR_DATA. Read → RD_REQ.
- WR_DATA: `axi_wready`=1. A W handshake latches data/strb → WR_REQ.
- WR_REQ / RD_REQ: `sc_req_valid`=1 with the current beat address; `sc_req_we`=1 (write) or 0 (read). Handshake → WR_WAIT / RD_WAIT.
- WR_WAIT: `sc_rsp_valid` ORs `sc_rsp_err` into the error flag. Then → WR_DATA if beats remain, else WR_RESP.
- WR_RESP: `axi_bvalid`=1; `bresp` = 2'b10 if the error flag is set, else 2'b00. Held until `bready` → IDLE.
- RD_WAIT: `sc_rsp_valid` latches rdata and err → RD_DATA.
- RD_DATA: `axi_rvalid`=1; `rresp` = 2'b10 on err, else 2'b00; `rlast` is 1 on beat len. Held stable until `rready`. Then → RD_REQ if beats remain, else IDLE.
- `sc_rsp_valid` outside the WAIT states is ignored.
- Beat address, all arithmetic modulo 2^ADDR_WIDTH, with N = 1<<size:
  - FIXED: constant.
  - INCR: next = (addr & ~(N-1)) + N.
  - WRAP: boundary B = (len+1)·N. next = (addr & ~(B-1)) | ((addr+N) & (B-1)).
  - 4 KB crossing is not checked.
- Error bursts skip the backend; `sc_req_valid` stays 0 for the whole burst. A burst is an error burst if any of:
  - burst == 2'b11;
  - size > log2(DATA_WIDTH/8);
  - WRAP with len ∉ {1,3,7,15}.
- Error burst handling:
  - Writes: still accept len+1 W beats, then respond with bresp 2'b10.
  - Reads: return len+1 beats, rdata 0, rresp 2'b10.

## Timing
- Reset values: all ready/valid outputs 0; `sc_req_*` 0; `axi_b*`/`axi_r*` 0; state IDLE; `last_rd` 0.
- Reset mid-burst drops the transaction; no B or R response is issued for it.
- Single-beat write, zero wait:
  - AW handshake at cycle 0, W at 1, `sc_req_valid` at 2.
  - Response accepted no earlier than 3; `bvalid` no earlier than 4.
- Single-beat read:
  - AR at 0, `sc_req_valid` at 1, response at ≥2, `rvalid` at ≥3.
- At most one outstanding backend request. Each beat costs at least 3 cycles (write) or 3 cycles (read).
- A request is held stable while `sc_req_ready`=0. R/B outputs are held stable while ready=0.

## Configuration
- `SC_AXI_BRIDGE_WLAST_CHK_EN` defined:
  - Setting any of the following sets the error flag (bresp 2'b10); the beat is still forwarded:
    - `wlast`=1 on a non-final beat;
    - `wlast`=0 on the final beat.
- Undefined: `wlast` is ignored; beat count comes only from awlen.

## Test plan
- Write awaddr 0x100, len 0, size 3, wdata 0xDEADBEEF, strb 0xFF, backend OK → one `sc_req` (we=1, addr 0x100), then bresp 2'b00 with bid = awid.
- INCR read araddr 0x204, len 3, size 3 → `sc_req_addr` 0x204, 0x208, 0x210, 0x218; 4 R beats; rlast only on the 4th; rid = arid.
- WRAP read araddr 0x38, len 3, size 3 → addresses 0x38, 0x20, 0x28, 0x30.
- AW and AR both valid out of reset → write granted first, read granted on the next IDLE. Repeat with both valid again → read is granted first.
- Backend `sc_rsp_err`=1 on beat 2 of a 4-beat write → bresp 2'b10. Same on a read → only beat 2 has rresp 2'b10.
- Read size 4 on a 64-bit bus, len 1 → no `sc_req_valid`; 2 beats with rdata 0 and rresp 2'b10. With the macro defined, a 2-beat write with early wlast → bresp 2'b10.
